// File: rtl/verin_manual_sequencer.sv
// Manual-mode sequencer for the tiller actuator (verin) power stage: arbitrates the babord/tribord
// requests into a ramped PWM duty and a direction, with dead-time, end-stops and an ADC watchdog.
module verin_manual_sequencer #(
  parameter int DUTY_W       = 8,
  parameter int ANGLE_W      = 12,
  parameter int RAMP_DIV     = 5000,
  parameter int DEADTIME_CYC = 50000,
  parameter int WDOG_CYC     = 2500000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mode_manual,
  input  logic               req_babord,
  input  logic               req_tribord,
  input  logic [DUTY_W-1:0]  duty_max,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               angle_valid,
  input  logic [ANGLE_W-1:0] butee_min,
  input  logic [ANGLE_W-1:0] butee_max,
  output logic [DUTY_W-1:0]  duty_out,
  output logic               sens_out,
  output logic               busy,
  output logic               limit_hit,
  output logic               fault,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    DEAD      = 3'd4
  } state_t;

  localparam int TMR_MAX = (RAMP_DIV > DEADTIME_CYC) ? RAMP_DIV : DEADTIME_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int WDOG_W  = $clog2(WDOG_CYC + 1);
  localparam logic [TMR_W-1:0]  RAMP_LAST = TMR_W'(RAMP_DIV - 1);
  localparam logic [TMR_W-1:0]  DEAD_LAST = TMR_W'(DEADTIME_CYC - 1);
  localparam logic [WDOG_W-1:0] WDOG_TRIP = WDOG_W'(WDOG_CYC);

  state_t              state, state_n;
  logic [TMR_W-1:0]    tmr, tmr_n;
  logic [DUTY_W-1:0]   duty_n, duty_inc, duty_dec;
  logic                sens_n, fault_n, limit_n;
  logic [ANGLE_W-1:0]  angle_l;
  logic [WDOG_W-1:0]   wdog_cnt;
  logic                lim_b, lim_t, lim_cur, req_valid, req_keep, wdog_trip, step;

  // angle_valid is a one-cycle strobe with no back-pressure: the sample is taken whenever it is high.
  assign lim_b     = (angle_l <= butee_min);
  assign lim_t     = (angle_l >= butee_max);
  assign lim_cur   = sens_out ? lim_t : lim_b;
  assign req_valid = (req_babord ^ req_tribord) && mode_manual && !fault &&
                     !(req_tribord ? lim_t : lim_b);
  assign req_keep  = req_valid && (req_tribord == sens_out);
  assign wdog_trip = (duty_out != '0) && (wdog_cnt == WDOG_TRIP);
  assign step      = (tmr == RAMP_LAST);
  assign duty_inc  = duty_out + 1'b1;
  assign duty_dec  = duty_out - 1'b1;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      angle_l  <= '0;
      wdog_cnt <= '0;
    end else begin
      if (angle_valid) angle_l <= angle;
      // Watchdog only measures ADC silence while the motor is actually driven.
      if (angle_valid || duty_out == '0) wdog_cnt <= '0;
      else if (wdog_cnt != WDOG_TRIP)    wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    duty_n  = duty_out;
    sens_n  = sens_out;
    fault_n = fault;
    limit_n = 1'b0;
    tmr_n   = tmr + 1'b1;
    case (state)
      IDLE: begin
        duty_n = '0;
        tmr_n  = '0;
        if (!mode_manual) fault_n = 1'b0;
        if (req_valid) begin
          if (req_tribord == sens_out) begin
            state_n = RAMP_UP;
          end else begin
            sens_n  = req_tribord;
            state_n = DEAD;
          end
        end
      end
      RAMP_UP, RUN, RAMP_DOWN: begin
        if (wdog_trip) begin
          fault_n = 1'b1;
          duty_n  = '0;
          state_n = DEAD;
        end else if (lim_cur) begin
          limit_n = 1'b1;
          duty_n  = '0;
          state_n = DEAD;
        end else if (state == RAMP_DOWN) begin
          if (duty_out == '0) begin
            state_n = DEAD;
          end else if (step) begin
            duty_n = duty_dec;
            tmr_n  = '0;
            if (duty_dec == '0) state_n = DEAD;
          end
        end else if (!req_keep) begin
          state_n = RAMP_DOWN;
        end else if (state == RUN) begin
          duty_n = duty_max;
          tmr_n  = tmr;
        end else if (duty_max <= duty_out) begin
          duty_n  = duty_max;
          state_n = RUN;
        end else if (step) begin
          duty_n = duty_inc;
          tmr_n  = '0;
          if (duty_inc == duty_max) state_n = RUN;
        end
      end
      DEAD: begin
        duty_n = '0;
        if (tmr == DEAD_LAST) state_n = IDLE;
      end
      default: begin
        duty_n  = '0;
        state_n = IDLE;
      end
    endcase
    // Every state entry restarts the shared ramp/dead-time timer.
    if (state_n != state) tmr_n = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tmr       <= '0;
      duty_out  <= '0;
      sens_out  <= 1'b0;
      fault     <= 1'b0;
      limit_hit <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      tmr       <= tmr_n;
      duty_out  <= duty_n;
      sens_out  <= sens_n;
      fault     <= fault_n;
      limit_hit <= limit_n;
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: doc/verin_manual_sequencer.md
Name: verin_manual_sequencer

Overview:
Sequences the tiller actuator (vérin) power stage in manual mode. It arbitrates the babord and tribord button requests and produces the PWM duty and direction (sens) commands for the vérin PWM generator. Duty ramps up and down, a dead-time is enforced on every stop or reversal, and the ADC position limits (butées) and ADC sample freshness are enforced. It sits between the button manager (debounced levels) and the vérin PWM/ADC block.

Parameters:
DUTY_W, 8, duty width (0 = off, 2^DUTY_W-1 = full)
ANGLE_W, 12, ADC angle width, unsigned
RAMP_DIV, 5000, clk cycles per ±1 duty step
DEADTIME_CYC, 50000, zero-duty cycles after any stop (1 ms at 50 MHz)
WDOG_CYC, 2500000, max clk cycles between angle_valid pulses while motor active

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
mode_manual  in  1  1 = manual mode enabled (stby off)
req_babord  in  1  debounced level, request motion toward babord (angle decreasing)
req_tribord  in  1  debounced level, request motion toward tribord (angle increasing)
duty_max  in  DUTY_W  target duty, sampled continuously
angle  in  ANGLE_W  latest ADC position
angle_valid  in  1  1-cycle strobe, angle is new
butee_min  in  ANGLE_W  babord end-stop
butee_max  in  ANGLE_W  tribord end-stop
duty_out  out  DUTY_W  PWM duty command
sens_out  out  1  direction, 0 = babord, 1 = tribord
busy  out  1  1 when state != IDLE
limit_hit  out  1  1-cycle pulse when a butée stops the motor
fault  out  1  sticky ADC watchdog fault

Behaviour:
- Reset (asynchronous, any state): duty_out=0, sens_out=0, busy=0, limit_hit=0, fault=0, state=IDLE, latched angle=0, counters=0.
- Angle latch: latch angle on angle_valid. lim_b = (angle_l <= butee_min); lim_t = (angle_l >= butee_max); unsigned compares.
- Valid request: exactly one of req_babord or req_tribord high, mode_manual=1, fault=0, and the requested side's limit not active. Both requests high counts as no request.
- FSM states: IDLE, RAMP_UP, RUN, RAMP_DOWN, DEAD.
- IDLE: duty 0.
  - Valid request with direction == sens_out -> RAMP_UP.
  - Valid request with direction != sens_out -> load the new sens_out that cycle, go to DEAD. sens_out never changes while duty_out != 0.
- RAMP_UP: duty_out += 1 every RAMP_DIV cycles until it equals duty_max -> RUN. If duty_max <= duty_out, clamp duty_out to duty_max and go to RUN the next cycle. duty_max=0 reaches RUN with duty 0.
- RUN: duty_out tracks duty_max in both directions, clamping immediately.
- Request lost in RAMP_UP or RUN (released, both pressed, opposite pressed, or mode_manual=0) -> RAMP_DOWN.
- RAMP_DOWN: duty_out -= 1 every RAMP_DIV cycles, saturating at 0. At 0 -> DEAD. A re-press during RAMP_DOWN is ignored.
- Butée (emergency stop): active limit in the current direction during RAMP_UP, RUN or RAMP_DOWN -> duty_out=0 next cycle, limit_hit=1 for one cycle, -> DEAD. No ramp.
- DEAD: duty 0; count DEADTIME_CYC cycles, then -> IDLE. Requests are ignored until IDLE.
- Watchdog: counter is cleared by angle_valid and only runs while duty_out != 0. On reaching WDOG_CYC: fault=1, duty_out=0 next cycle, -> DEAD. fault clears only when mode_manual=0 in IDLE.
- Priority in one cycle: reset > watchdog > butée > request loss > ramp step.
- Ramp divider restarts on every state entry, so the first step lands RAMP_DIV cycles after entry.
- All outputs are registered.

Test Plan (RAMP_DIV=4, DEADTIME_CYC=10, WDOG_CYC=200, butee_min=100, butee_max=3000, angle=2000 refreshed every 50 cycles):
1. mode_manual=1, duty_max=8, hold req_tribord -> sens 0→1 in IDLE, 10 cycles DEAD, then duty 1..8 one step per 4 cycles, RUN at 8; release -> duty 8..0 over 32 cycles, 10 DEAD, IDLE, busy=0.
2. Running tribord at duty 8, angle_valid with angle=3000 -> duty_out=0 next cycle, limit_hit single pulse, DEAD. Re-press tribord -> no motion. Press babord -> sens=0, then ramps.
3. Both buttons pressed from IDLE -> stays IDLE, duty 0. Both pressed during RUN -> RAMP_DOWN.
4. RUN at duty 8, duty_max changed to 3 -> duty_out=3 next cycle. Changed to 200 -> duty_out=200 next cycle.
5. RUN with angle_valid stopped -> after 200 cycles fault=1, duty 0, DEAD. Requests ignored. mode_manual 0 then 1 -> fault=0, new request works.
6. reset_n low mid-RAMP_UP at duty 5 -> all outputs 0 immediately without a clk edge. Release with req held -> restarts from IDLE, sens=0.
